// File: rtl/mem_arb_pkg.sv
// Shared encodings for the byte-serial memory port arbiter: FSM states,
// requester IDs and word geometry.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: when defined, a pointer picks the preferred side on contention.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  req_id_t ptr,
`endif
    output logic    valid,
    output req_id_t winner
);

    always_comb begin
        valid  = if_req | d_req;
        winner = REQ_IF;
        if (d_req && !if_req) begin
            winner = REQ_D;
        end else if (d_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ptr;
`else
            winner = REQ_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide big-endian memory between fetch and load/store; each
// grant becomes four byte accesses, MSB first. ARB_ROUND_ROBIN_EN selects round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    req_id_t           id_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              we_reg;
    logic [31:0]       wdata_reg;
    logic [7:0]        asm_reg [WORD_BYTES-1];
    logic [31:0]       if_rdata_reg;
    logic [31:0]       d_rdata_reg;

    logic    pick_valid;
    req_id_t pick_winner;

    // Request address bits above the memory width are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t ptr_reg;

    arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_req),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );
`else
    arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_req),
        .valid  (pick_valid),
        .winner (pick_winner)
    );
`endif

    logic [7:0] wbyte [WORD_BYTES];
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_wbyte
        assign wbyte[gi] = wdata_reg[8*(WORD_BYTES-1-gi) +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            id_reg       <= REQ_D;
            base_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            for (int i = 0; i < WORD_BYTES - 1; i++) begin
                asm_reg[i] <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            ptr_reg      <= REQ_D;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        id_reg    <= pick_winner;
                        base_reg  <= (pick_winner == REQ_D) ? d_addr[ADDR_W-1:0]
                                                            : if_addr[ADDR_W-1:0];
                        we_reg    <= (pick_winner == REQ_D) && d_we;
                        wdata_reg <= d_wdata;
                        cnt_reg   <= '0;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    // The final byte goes straight into the visible word so it
                    // only changes once the whole word is assembled.
                    if (!we_reg) begin
                        if (cnt_reg != LAST_CNT) begin
                            asm_reg[cnt_reg] <= mem_rdata;
                        end else if (id_reg == REQ_D) begin
                            d_rdata_reg <= {asm_reg[0], asm_reg[1], asm_reg[2], mem_rdata};
                        end else begin
                            if_rdata_reg <= {asm_reg[0], asm_reg[1], asm_reg[2], mem_rdata};
                        end
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_reg   <= (ptr_reg == REQ_D) ? REQ_IF : REQ_D;
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign if_ack    = (state_reg == DONE) && (id_reg == REQ_IF);
    assign d_ack     = (state_reg == DONE) && (id_reg == REQ_D);
    assign mem_addr  = (state_reg == XFER) ? base_reg + ADDR_W'(cnt_reg) : '0;
    assign mem_we    = (state_reg == XFER) && we_reg;
    assign mem_wdata = ((state_reg == XFER) && we_reg) ? wbyte[cnt_reg] : '0;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level schedule model plus directed
// literal pins and randomized two-requester traffic.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0] phys_mem [65536];
    logic [7:0] mdl_mem  [65536];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_rdata = phys_mem[mem_addr];

    typedef struct packed {
        logic        busy;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic        ia;
        logic        da;
        logic [31:0] ir;
        logic [31:0] dr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cur_if = '0;
    logic [31:0] cur_d = '0;
    logic        ptr_d = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-transaction model: on a grant, lay out the next six cycles.
    task automatic model_step();
        if (!rst_n) begin
            exp_q.delete();
            cur_if = '0;
            cur_d  = '0;
            ptr_d  = 1'b1;
        end else if (exp_q.size() == 0 && (if_req || d_req)) begin
            logic        pick_d;
            logic [15:0] b;
            logic        w;
            logic [31:0] word;
            exp_t        e;
            if (RR) begin
                pick_d = d_req && (!if_req || ptr_d);
                ptr_d  = !ptr_d;
            end else begin
                pick_d = d_req;
            end
            b    = pick_d ? d_addr[15:0] : if_addr[15:0];
            w    = pick_d && d_we;
            word = '0;
            for (int k = 0; k < 4; k++) begin
                logic [15:0] a;
                a    = b + 16'(k);
                e    = '0;
                e.busy = 1'b1;
                e.addr = a;
                e.we   = w;
                e.wd   = w ? 8'(d_wdata >> (24 - 8*k)) : 8'h00;
                e.ir   = cur_if;
                e.dr   = cur_d;
                exp_q.push_back(e);
                if (w) mdl_mem[a] = 8'(d_wdata >> (24 - 8*k));
                else   word = {word[23:0], mdl_mem[a]};
            end
            if (!w) begin
                if (pick_d) cur_d = word;
                else        cur_if = word;
            end
            e      = '0;
            e.busy = 1'b1;
            e.ia   = !pick_d;
            e.da   = pick_d;
            e.ir   = cur_if;
            e.dr   = cur_d;
            exp_q.push_back(e);
            e      = '0;
            e.ir   = cur_if;
            e.dr   = cur_d;
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_step();
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e    = '0;
                e.ir = cur_if;
                e.dr = cur_d;
            end
            chk("busy", 64'(busy), 64'(e.busy));
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            chk("mem_we", 64'(mem_we), 64'(e.we));
            chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
            chk("if_ack", 64'(if_ack), 64'(e.ia));
            chk("d_ack", 64'(d_ack), 64'(e.da));
            chk("if_rdata", 64'(if_rdata), 64'(e.ir));
            chk("d_rdata", 64'(d_rdata), 64'(e.dr));
        end
    endtask

    task automatic start(input bit is_d, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, output int t0);
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        t0 = cyc;
    endtask

    task automatic drop(input bit is_d);
        @(posedge clk);
        #1;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic wait_ack(input bit is_d, output int c);
        bit found;
        found = 1'b0;
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_d ? d_ack : if_ack) begin
                c = cyc;
                found = 1'b1;
                break;
            end
        end
        chk(is_d ? "d_ack_seen" : "if_ack_seen", 64'(found), 64'd1);
    endtask

    task automatic xact(input bit is_d, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [63:0] addrs,
                        output logic [31:0] wbytes, output logic [3:0] wes,
                        output int lat, output logic [31:0] rd);
        int t0;
        int c;
        start(is_d, we, a, wd, t0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            addrs[63-16*k -: 16] = mem_addr;
            wbytes[31-8*k -: 8]  = mem_wdata;
            wes[3-k]             = mem_we;
        end
        wait_ack(is_d, c);
        lat = c - t0;
        rd  = is_d ? d_rdata : if_rdata;
        drop(is_d);
    endtask

    task automatic contend(output bit first_d, output int lat1, output int lat2);
        int  t0;
        int  c1;
        int  c2;
        bit  found;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h0000_0104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        t0 = cyc;
        found = 1'b0;
        first_d = 1'b0;
        c1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                first_d = d_ack;
                c1 = cyc;
                found = 1'b1;
                break;
            end
        end
        chk("contend_first_ack_seen", 64'(found), 64'd1);
        drop(first_d);
        wait_ack(!first_d, c2);
        drop(!first_d);
        lat1 = c1 - t0;
        lat2 = c2 - t0;
    endtask

    task automatic rand_requester(input bit is_d, input int n);
        for (int j = 0; j < n; j++) begin
            logic [31:0] a;
            bit          we;
            int          t0;
            int          c;
            repeat ($urandom_range(0, 8)) @(posedge clk);
            we = is_d && ($urandom_range(0, 1) == 1);
            if (we) a = {$urandom_range(0, 65535), 16'h0100 + 16'($urandom_range(0, 63))};
            else if ($urandom_range(0, 7) == 0)
                a = {$urandom_range(0, 65535), 16'hFFFC + 16'($urandom_range(0, 3))};
            else
                a = {$urandom_range(0, 65535), 16'h0100 + 16'($urandom_range(0, 63))};
            start(is_d, we, a, $urandom, t0);
            wait_ack(is_d, c);
            drop(is_d);
        end
    endtask

    initial begin
        logic [63:0] addrs;
        logic [31:0] wbytes;
        logic [31:0] rd;
        logic [3:0]  wes;
        int          lat;
        int          lat2;
        int          t0;
        int          c;
        bit          first_d;

        for (int i = 0; i < 65536; i++) begin
            phys_mem[i] = 8'($urandom);
            mdl_mem[i]  = phys_mem[i];
        end
        phys_mem[0] = 8'h20; phys_mem[1] = 8'h08; phys_mem[2] = 8'h00; phys_mem[3] = 8'h05;
        for (int i = 0; i < 4; i++) mdl_mem[i] = phys_mem[i];

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                model_step();
            end
            forever begin
                @(negedge clk);
                compare_step();
            end
            forever begin
                @(posedge clk);
                if (mem_we) phys_mem[mem_addr] <= mem_wdata;
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_if_rdata", 64'(if_rdata), 64'd0);
        chk("reset_d_rdata", 64'(d_rdata), 64'd0);

        // Contention right after reset: data preferred in both builds.
        contend(first_d, lat, lat2);
        chk("contend1_d_first", 64'(first_d), 64'd1);
        chk("contend1_first_lat", 64'(lat), 64'd5);
        chk("contend1_second_lat", 64'(lat2), 64'd11);

        xact(1'b0, 1'b0, 32'h0000_0000, 32'h0, addrs, wbytes, wes, lat, rd);
        chk("fetch0_addrs", addrs, 64'h0000_0001_0002_0003);
        chk("fetch0_we", 64'(wes), 64'h0);
        chk("fetch0_lat", 64'(lat), 64'd5);
        chk("fetch0_rdata", 64'(rd), 64'h2008_0005);

        // Three grants so far: round-robin pointer now favours fetch.
        contend(first_d, lat, lat2);
        chk("contend2_d_first", 64'(first_d), RR ? 64'd0 : 64'd1);
        chk("contend2_first_lat", 64'(lat), 64'd5);
        chk("contend2_second_lat", 64'(lat2), 64'd11);

        xact(1'b1, 1'b1, 32'hABCD_0010, 32'hDEAD_BEEF, addrs, wbytes, wes, lat, rd);
        chk("store_addrs", addrs, 64'h0010_0011_0012_0013);
        chk("store_bytes", 64'(wbytes), 64'hDEAD_BEEF);
        chk("store_we", 64'(wes), 64'hF);
        chk("store_lat", 64'(lat), 64'd5);
        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, addrs, wbytes, wes, lat, rd);
        chk("load_back", 64'(rd), 64'hDEAD_BEEF);

        xact(1'b0, 1'b0, 32'h0000_FFFE, 32'h0, addrs, wbytes, wes, lat, rd);
        chk("wrap_addrs", addrs, 64'hFFFE_FFFF_0000_0001);

        // Requester withdraws mid-load; the transfer still completes.
        start(1'b1, 1'b0, 32'h0000_0010, 32'h0, t0);
        @(posedge clk); #1;
        @(posedge clk); #1 d_req = 1'b0;
        wait_ack(1'b1, c);
        chk("drop_lat", 64'(c - t0), 64'd5);
        chk("drop_rdata", 64'(d_rdata), 64'hDEAD_BEEF);

        // Reset in the middle of a store.
        start(1'b1, 1'b1, 32'h0000_8000, 32'h1122_3344, t0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_acks", 64'({if_ack, d_ack}), 64'd0);
        chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack_after_reset", 64'({if_ack, d_ack}), 64'd0);
        end
        xact(1'b0, 1'b0, 32'h0000_0000, 32'h0, addrs, wbytes, wes, lat, rd);
        chk("post_reset_lat", 64'(lat), 64'd5);
        chk("post_reset_rdata", 64'(rd), 64'h2008_0005);

        fork
            rand_requester(1'b0, 40);
            rand_requester(1'b1, 40);
        join
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
